mm_load_sequencer: RTL and testbench

- Sequences the 3x3 memory bank and the downstream MAC array for one matrix multiply.
- Accepts a valid/ready nibble stream: 9 W elements, then 9 X elements, row-major.
- Drives the bank's load_w/load_x strobes, then steps unload1/unload2/unload3 in order with an accumulate enable for the MAC array. Each step presents W column k and X row k; the three outer products sum to C = W*X.
- Pulses done when the product is complete.

---
 rtl/mm_pkg.sv | 39 +++
 rtl/mm_elem_counter.sv | 36 +++
 rtl/mm_load_sequencer.sv | 162 ++++++++++++++++
 tb/tb_mm_load_sequencer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mm_pkg
// Purpose  : Shared constants, state encoding and unload-select helper for
//            the 3x3 matrix-multiply bank, MAC array and load sequencer.
// Revision : 1.0  initial release
// ============================================================================
package mm_pkg;

  localparam int MM_DIM    = 3;
  localparam int MM_ELEMS  = MM_DIM * MM_DIM;
  localparam int MM_DATA_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLR    = 3'd1,
    ST_LOAD_W = 3'd2,
    ST_LOAD_X = 3'd3,
    ST_STEP   = 3'd4,
    ST_DONE   = 3'd5
  } mm_state_e;

  localparam logic [2:0] MM_SEL_NONE = 3'b000;

  // One-hot unload select for step k (1..3); anything else selects nothing.
  function automatic logic [2:0] mm_unload_sel(input logic [1:0] k);
    logic [2:0] sel;
    sel = MM_SEL_NONE;
    case (k)
      2'd1:    sel = 3'b001;
      2'd2:    sel = 3'b010;
      2'd3:    sel = 3'b100;
      default: sel = MM_SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mm_elem_counter.sv
`default_nettype none
// ============================================================================
// Module   : mm_elem_counter
// Purpose  : 4-bit element counter with clear, increment and a terminal flag
//            at MM_ELEMS-1; shared by the W and X load phases.
// Revision : 1.0  initial release
// ============================================================================
module mm_elem_counter
  import mm_pkg::*;
(
  input  logic clk,
  input  logic clear_n,
  input  logic clr,
  input  logic inc,
  output logic last
);

  localparam logic [3:0] c_LAST = 4'(MM_ELEMS - 1);

  logic [3:0] r_count;

  assign last = (r_count == c_LAST);

  // Holds at the terminal value rather than wrapping; clear has priority.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_count <= 4'd0;
    end else if (clr) begin
      r_count <= 4'd0;
    end else if (inc && !last) begin
      r_count <= r_count + 4'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mm_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mm_load_sequencer
// Purpose  : Loads W then X into the 3x3 bank from a valid/ready stream and
//            steps the three unload selects with MAC accumulate control.
// Revision : 1.0  initial release
// ============================================================================
module mm_load_sequencer
  import mm_pkg::*;
#(
  parameter int DATA_W = MM_DATA_W,
  parameter int DIM    = MM_DIM,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              go,
  input  logic              abort,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_load_w,
  output logic              mem_load_x,
  output logic              mem_clear,
  output logic              unload1,
  output logic              unload2,
  output logic              unload3,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] c_LAST_K = 2'(DIM);
  localparam logic [1:0] c_SETTLE = 2'(SETTLE);

  mm_state_e  r_state;
  logic [1:0] r_k;
  logic [1:0] r_wait;
  logic [2:0] r_unload;
  logic       r_mem_clear;
  logic       r_acc_clr;
  logic       r_acc_en;
  logic       r_busy;
  logic       r_done;

  logic       w_loading;
  logic       w_hs;
  logic       w_last;
  logic       w_abort;
  logic       w_cnt_clr;

  assign w_loading  = (r_state == ST_LOAD_W) || (r_state == ST_LOAD_X);
  assign w_abort    = abort && (r_state != ST_IDLE);
  assign in_ready   = w_loading && !abort;
  assign w_hs       = in_valid && in_ready;
  assign mem_load_w = w_hs && (r_state == ST_LOAD_W);
  assign mem_load_x = w_hs && (r_state == ST_LOAD_X);
  assign mem_data   = in_ready ? in_data : '0;
  assign w_cnt_clr  = (r_state == ST_CLR) || (w_hs && w_last) || w_abort;

  assign mem_clear = r_mem_clear;
  assign unload1   = r_unload[0];
  assign unload2   = r_unload[1];
  assign unload3   = r_unload[2];
  assign acc_clr   = r_acc_clr;
  assign acc_en    = r_acc_en;
  assign busy      = r_busy;
  assign done      = r_done;

  mm_elem_counter u_elem_counter (
    .clk     (clk),
    .clear_n (clear_n),
    .clr     (w_cnt_clr),
    .inc     (w_hs),
    .last    (w_last)
  );

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_state     <= ST_IDLE;
      r_k         <= 2'd0;
      r_wait      <= 2'd0;
      r_unload    <= MM_SEL_NONE;
      r_mem_clear <= 1'b0;
      r_acc_clr   <= 1'b0;
      r_acc_en    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_mem_clear <= 1'b0;
      r_acc_clr   <= 1'b0;
      r_acc_en    <= 1'b0;
      r_done      <= 1'b0;
      if (w_abort) begin
        // Abandon the job and wipe the partially written bank.
        r_state     <= ST_IDLE;
        r_k         <= 2'd0;
        r_wait      <= 2'd0;
        r_unload    <= MM_SEL_NONE;
        r_mem_clear <= 1'b1;
        r_busy      <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (go) begin
              r_state     <= ST_CLR;
              r_mem_clear <= 1'b1;
              r_busy      <= 1'b1;
            end
          end
          ST_CLR: begin
            r_state <= ST_LOAD_W;
          end
          ST_LOAD_W: begin
            if (w_hs && w_last) begin
              r_state <= ST_LOAD_X;
            end
          end
          ST_LOAD_X: begin
            if (w_hs && w_last) begin
              r_state   <= ST_STEP;
              r_k       <= 2'd1;
              r_wait    <= 2'd0;
              r_unload  <= mm_unload_sel(2'd1);
              r_acc_clr <= 1'b1;
            end
          end
          ST_STEP: begin
            // Hold each select SETTLE extra cycles; accumulate on the last one.
            if (r_wait != c_SETTLE) begin
              r_wait   <= r_wait + 2'd1;
              r_acc_en <= ((r_wait + 2'd1) == c_SETTLE);
            end else if (r_k != c_LAST_K) begin
              r_k      <= r_k + 2'd1;
              r_wait   <= 2'd0;
              r_unload <= mm_unload_sel(r_k + 2'd1);
            end else begin
              r_state  <= ST_DONE;
              r_k      <= 2'd0;
              r_wait   <= 2'd0;
              r_unload <= MM_SEL_NONE;
              r_done   <= 1'b1;
            end
          end
          ST_DONE: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state  <= ST_IDLE;
            r_unload <= MM_SEL_NONE;
            r_busy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mm_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mm_load_sequencer
// Purpose  : Scoreboard bench for mm_load_sequencer with a bank/MAC model;
//            instance 0 uses SETTLE=1, instance 1 uses SETTLE=3.
// Revision : 1.0  initial release
// ============================================================================
module tb_mm_load_sequencer;

  localparam int c_N = 2;
  localparam int c_W = 4;

  localparam logic [3:0] c_EV_W    = 4'd1;
  localparam logic [3:0] c_EV_X    = 4'd2;
  localparam logic [3:0] c_EV_STEP = 4'd3;
  localparam logic [3:0] c_EV_DONE = 4'd4;
  localparam logic [3:0] c_EV_RES  = 4'd5;
  localparam logic [3:0] c_EV_CLR  = 4'd6;

  typedef struct packed {
    logic [3:0]  kind;
    logic [15:0] val;
  } ev_t;

  logic clk = 1'b0;
  logic clear_n = 1'b0;

  logic           go        [c_N];
  logic           abort     [c_N];
  logic [c_W-1:0] in_data   [c_N];
  logic           in_valid  [c_N];
  logic           in_ready  [c_N];
  logic [c_W-1:0] mem_data  [c_N];
  logic           mem_load_w[c_N];
  logic           mem_load_x[c_N];
  logic           mem_clear [c_N];
  logic           unload1   [c_N];
  logic           unload2   [c_N];
  logic           unload3   [c_N];
  logic           acc_clr   [c_N];
  logic           acc_en    [c_N];
  logic           busy      [c_N];
  logic           done      [c_N];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < c_N; gi++) begin : g_dut
    mm_load_sequencer #(
      .DATA_W (c_W),
      .DIM    (3),
      .SETTLE ((gi == 0) ? 1 : 3)
    ) u_dut (
      .clk        (clk),
      .clear_n    (clear_n),
      .go         (go[gi]),
      .abort      (abort[gi]),
      .in_data    (in_data[gi]),
      .in_valid   (in_valid[gi]),
      .in_ready   (in_ready[gi]),
      .mem_data   (mem_data[gi]),
      .mem_load_w (mem_load_w[gi]),
      .mem_load_x (mem_load_x[gi]),
      .mem_clear  (mem_clear[gi]),
      .unload1    (unload1[gi]),
      .unload2    (unload2[gi]),
      .unload3    (unload3[gi]),
      .acc_clr    (acc_clr[gi]),
      .acc_en     (acc_en[gi]),
      .busy       (busy[gi]),
      .done       (done[gi])
    );
  end

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  ev_t q0[$];
  ev_t q1[$];

  // Bank/MAC model state, written only by the monitor.
  int         wm  [c_N][9];
  int         xm  [c_N][9];
  int         wp  [c_N];
  int         xp  [c_N];
  int         cm  [c_N][3][3];
  logic [2:0] run_sel [c_N];
  int         run_len [c_N];
  int         run_acc [c_N];
  int         run_clr [c_N];
  int         last_x   [c_N];
  int         last_done[c_N];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int settle_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [15:0] step_code(input int k, input int len, input int acc, input int clr);
    return {4'(k), 4'(len), 4'(acc), 4'(clr)};
  endfunction

  function automatic logic [15:0] clr_code(input int b, input int gap);
    return 16'(b * 256 + gap);
  endfunction

  function automatic int sel_k(input logic [2:0] sel);
    case (sel)
      3'b001:  return 1;
      3'b010:  return 2;
      3'b100:  return 3;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h", name, d, act, exp);
    end
  endtask

  task automatic push(input int d, input logic [3:0] kind, input logic [15:0] val);
    ev_t e;
    e = {kind, val};
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic observe(input int d, input logic [3:0] kind, input logic [15:0] val);
    ev_t e;
    ev_t a;
    int  sz;
    a  = {kind, val};
    sz = (d == 0) ? q0.size() : q1.size();
    vectors++;
    if (sz == 0) begin
      miscompares++;
      $display("FAIL ev_unexpected dut%0d: got kind %0d val 0x%04h, expected nothing", d, kind, val);
    end else begin
      e = (d == 0) ? q0.pop_front() : q1.pop_front();
      if (a !== e) begin
        miscompares++;
        $display("FAIL ev dut%0d @%0d: got kind %0d val 0x%04h, expected kind %0d val 0x%04h",
                 d, cyc, kind, val, e.kind, e.val);
      end
    end
  endtask

  task automatic mon_one(input int d);
    logic [2:0] sel;
    int         gap;
    int         k;
    sel = {unload3[d], unload2[d], unload1[d]};
    if (mem_clear[d]) begin
      gap = cyc - last_done[d];
      if (gap > 15) gap = 15;
      observe(d, c_EV_CLR, clr_code(int'(busy[d]), gap));
      wp[d] = 0;
      xp[d] = 0;
      for (int i = 0; i < 9; i++) begin wm[d][i] = 0; xm[d][i] = 0; end
    end
    if (mem_load_w[d]) begin
      observe(d, c_EV_W, 16'(mem_data[d]));
      if (wp[d] < 9) wm[d][wp[d]] = int'(mem_data[d]);
      wp[d]++;
    end
    if (mem_load_x[d]) begin
      observe(d, c_EV_X, 16'(mem_data[d]));
      if (xp[d] < 9) xm[d][xp[d]] = int'(mem_data[d]);
      xp[d]++;
      last_x[d] = cyc;
    end
    if (acc_clr[d]) begin
      for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) cm[d][i][j] = 0;
    end
    k = sel_k(sel);
    if (acc_en[d] && k != 0) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          cm[d][i][j] += wm[d][i*3 + k - 1] * xm[d][(k-1)*3 + j];
    end
    if (sel != run_sel[d]) begin
      if (run_sel[d] != 3'b000)
        observe(d, c_EV_STEP, step_code(sel_k(run_sel[d]), run_len[d], run_acc[d], run_clr[d]));
      run_sel[d] = sel;
      run_len[d] = 0;
      run_acc[d] = 0;
      run_clr[d] = 0;
    end
    if (sel != 3'b000) begin
      run_len[d]++;
      if (acc_en[d])  run_acc[d] = (run_acc[d] == 0) ? run_len[d] : 15;
      if (acc_clr[d]) run_clr[d] = (run_clr[d] == 0) ? run_len[d] : 15;
    end
    if (done[d]) begin
      observe(d, c_EV_DONE, 16'(cyc - last_x[d]));
      last_done[d] = cyc;
      for (int j = 0; j < 3; j++) observe(d, c_EV_RES, 16'(cm[d][0][j]));
    end
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      for (int d = 0; d < c_N; d++) mon_one(d);
    end
  endtask

  task automatic check_zero(input string name, input int d);
    check(name, d, 32'({in_ready[d], mem_data[d], mem_load_w[d], mem_load_x[d], mem_clear[d],
                        unload1[d], unload2[d], unload3[d], acc_clr[d], acc_en[d], busy[d], done[d]}), 32'd0);
  endtask

  task automatic start(input int d);
    go[d] = 1'b1;
    push(d, c_EV_CLR, clr_code(1, 15));
    @(posedge clk); #1;
    go[d] = 1'b0;
    check("clr_in_ready", d, 32'(in_ready[d]), 32'd0);
    check("clr_busy", d, 32'(busy[d]), 32'd1);
    @(posedge clk); #1;
    check("go_to_ready", d, 32'(in_ready[d]), 32'd1);
  endtask

  // W = 1..9 then X = 9..1; optional 1,0,0 valid stall; abort on element abort_at.
  task automatic feed(input int d, input bit stall, input int abort_at);
    logic [c_W-1:0] v;
    int wd;
    for (int n = 0; n < 18; n++) begin
      v = (n < 9) ? c_W'(n + 1) : c_W'(18 - n);
      in_data[d]  = v;
      in_valid[d] = 1'b1;
      if (n == abort_at) begin
        abort[d] = 1'b1;
        push(d, c_EV_CLR, clr_code(0, 15));
        @(posedge clk); #1;
        abort[d]    = 1'b0;
        in_valid[d] = 1'b0;
        check("abort_busy", d, 32'(busy[d]), 32'd0);
        check("abort_in_ready", d, 32'(in_ready[d]), 32'd0);
        return;
      end
      push(d, (n < 9) ? c_EV_W : c_EV_X, 16'(v));
      wd = 0;
      do begin @(negedge clk); wd++; end while (!in_ready[d] && wd < 40);
      if (!in_ready[d]) begin
        vectors++;
        miscompares++;
        $display("FAIL handshake_timeout dut%0d: element %0d never accepted", d, n);
        in_valid[d] = 1'b0;
        return;
      end
      @(posedge clk); #1;
      if (stall) begin
        in_valid[d] = 1'b0;
        in_data[d]  = 4'hF;
        repeat (2) @(posedge clk);
        #1;
      end
    end
    in_valid[d] = 1'b0;
    in_data[d]  = '0;
  endtask

  task automatic push_tail(input int d);
    int s;
    s = settle_of(d);
    for (int k = 1; k <= 3; k++) push(d, c_EV_STEP, step_code(k, s + 1, s + 1, (k == 1) ? 1 : 0));
    push(d, c_EV_DONE, 16'(3 * (s + 1) + 1));
    push(d, c_EV_RES, 16'd30);
    push(d, c_EV_RES, 16'd24);
    push(d, c_EV_RES, 16'd18);
  endtask

  task automatic wait_done(input int d);
    int wd;
    wd = 0;
    do begin @(negedge clk); wd++; end while (!done[d] && wd < 40);
    if (!done[d]) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout dut%0d: no done within 40 cycles", d);
    end
  endtask

  task automatic full_job(input int d, input bit stall);
    start(d);
    feed(d, stall, -1);
    push_tail(d);
    wait_done(d);
    repeat (20) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int d = 0; d < c_N; d++) begin
      go[d] = 1'b0; abort[d] = 1'b0; in_data[d] = '0; in_valid[d] = 1'b0;
      wp[d] = 0; xp[d] = 0; run_sel[d] = 3'b000; run_len[d] = 0;
      run_acc[d] = 0; run_clr[d] = 0; last_x[d] = 0; last_done[d] = -1000;
      for (int i = 0; i < 9; i++) begin wm[d][i] = 0; xm[d][i] = 0; end
      for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) cm[d][i][j] = 0;
    end
    fork
      monitor_loop();
    join_none

    #12;
    for (int d = 0; d < c_N; d++) check_zero("reset_outputs", d);
    @(negedge clk);
    clear_n = 1'b1;
    @(posedge clk); #1;

    // Plain runs on both settle configurations.
    full_job(0, 1'b0);
    full_job(1, 1'b0);

    // Stalled stream.
    full_job(0, 1'b1);

    // Abort on the 5th W handshake, then a clean job.
    start(0);
    feed(0, 1'b0, 4);
    repeat (20) @(posedge clk);
    #1;
    full_job(0, 1'b0);

    // Abort while idle must do nothing.
    abort[0] = 1'b1;
    @(posedge clk); #1;
    abort[0] = 1'b0;
    check("idle_abort_busy", 0, 32'(busy[0]), 32'd0);
    repeat (3) @(posedge clk);
    #1;

    // go held high: back-to-back jobs, second CLR two cycles after done.
    go[0] = 1'b1;
    push(0, c_EV_CLR, clr_code(1, 15));
    @(posedge clk); #1;
    feed(0, 1'b0, -1);
    push_tail(0);
    push(0, c_EV_CLR, clr_code(1, 2));
    wait_done(0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    go[0] = 1'b0;
    feed(0, 1'b0, -1);
    push_tail(0);
    wait_done(0);
    repeat (20) @(posedge clk);
    #1;

    // Reset asserted during step k=2 of the SETTLE=1 instance.
    start(0);
    feed(0, 1'b0, -1);
    push(0, c_EV_STEP, step_code(1, 2, 2, 1));
    push(0, c_EV_STEP, step_code(2, 1, 0, 0));
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    clear_n = 1'b0;
    #1;
    for (int d = 0; d < c_N; d++) check_zero("async_reset_outputs", d);
    repeat (2) @(posedge clk);
    @(negedge clk);
    clear_n = 1'b1;
    @(posedge clk); #1;
    check_zero("post_reset_idle", 0);
    repeat (20) @(posedge clk);
    #1;

    check("queue_drained", 0, 32'(q0.size()), 32'd0);
    check("queue_drained", 1, 32'(q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
